// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    COOL
  } arb_state_e;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int TO_CYC_DEF = 200000;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: the first set request strictly after ptr,
// wrapping modulo NREQ, wins.
module i2c_rr_pick #(
  parameter int NREQ = 2,
  parameter int PTRW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [PTRW-1:0] idx,
  output logic            valid
);

  always_comb begin
    int unsigned cand;
    cand   = 0;
    gnt_oh = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (k + ptr) % NREQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = PTRW'(cand);
        gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NREQ requesters: round-robin grant, latched
// request fields, enable/ready handshake sequencing and per-phase timeout.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int TO_CYC = TO_CYC_DEF,
  parameter int TOW    = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [ADDR_W*NREQ-1:0] req_addr,
  input  logic [DATA_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_rw,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic                   m_enable,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_rw,
  input  logic                   m_ready,
  input  logic [DATA_W-1:0]      m_data_out
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e          state_q, state_d;
  logic [TOW-1:0]      tcnt_q, tcnt_d;
  logic [PTRW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_d, done_d, err_d;
  logic                m_enable_d, busy_d, m_rw_d;
  logic [DATA_W-1:0]   rd_data_d, m_data_d;
  logic [ADDR_W-1:0]   m_addr_d;
  logic [NREQ-1:0]     pick_oh;
  logic [PTRW-1:0]     pick_idx;
  logic                pick_valid;
  logic                last_tick;

  i2c_rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign last_tick = (tcnt_q == TOW'(TO_CYC - 1));

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt;
    done_d     = '0;
    err_d      = '0;
    m_enable_d = m_enable;
    rd_data_d  = rd_data;
    m_addr_d   = m_addr;
    m_data_d   = m_data;
    m_rw_d     = m_rw;

    unique case (state_q)
      IDLE: begin
        if (pick_valid && m_ready) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
              m_addr_d = req_addr[i*ADDR_W +: ADDR_W];
              m_data_d = req_data[i*DATA_W +: DATA_W];
              m_rw_d   = req_rw[i];
            end
          end
          gnt_d      = pick_oh;
          ptr_d      = pick_idx;
          tcnt_d     = '0;
          m_enable_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!m_ready) begin
          m_enable_d = 1'b0;
          tcnt_d     = '0;
          state_d    = WAIT;
        end else if (last_tick) begin
          m_enable_d = 1'b0;
          err_d      = gnt;
          state_d    = COOL;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WAIT: begin
        // A completed transfer takes precedence over a timeout in the same cycle.
        if (m_ready) begin
          if (m_rw) rd_data_d = m_data_out;
          done_d  = gnt;
          state_d = COOL;
        end else if (last_tick) begin
          err_d   = gnt;
          state_d = COOL;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      COOL: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      ptr_q    <= PTRW'(NREQ - 1);
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
      m_enable <= 1'b0;
      rd_data  <= '0;
      m_addr   <= '0;
      m_data   <= '0;
      m_rw     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      ptr_q    <= ptr_d;
      gnt      <= gnt_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
      m_enable <= m_enable_d;
      rd_data  <= rd_data_d;
      m_addr   <= m_addr_d;
      m_data   <= m_data_d;
      m_rw     <= m_rw_d;
    end
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares one i2c_master_controller between NREQ requesters (sensor poller, LED/config writer, debug port).
- Arbitrates round-robin and latches the winner's addr/data/rw.
- Sequences the master's enable/ready handshake, returns read data, and reports done or timeout per requester.
- Sits between requester logic and the master in the top level, replacing the fixed addr/rw/enable tie-offs.

Parameters:
NREQ, 2, number of requesters (2..8).
TO_CYC, 200000, clk cycles allowed per handshake phase before abort.
TOW, 18, timeout counter width; must satisfy 2^TOW > TO_CYC.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester request level; held until done/err.
req_addr  in  7*NREQ  7-bit slave address, requester i at [7i+6:7i].
req_data  in  8*NREQ  write byte, requester i at [8i+7:8i].
req_rw  in  NREQ  1=read, 0=write.
gnt  out  NREQ  one-hot grant, high for the whole transaction.
done  out  NREQ  one-cycle pulse to the granted requester on success.
err  out  NREQ  one-cycle pulse to the granted requester on timeout.
rd_data  out  8  read byte, valid from done pulse until the next read completes.
busy  out  1  high in any state other than IDLE.
m_enable  out  1  to master enable.
m_addr  out  7  to master addr.
m_data  out  8  to master data_in.
m_rw  out  1  to master rw.
m_ready  in  1  master ready (high = idle).
m_data_out  in  8  master read data.

Behaviour:
- Reset (rst=0, async): state=IDLE; gnt, done, err, m_enable, busy = 0; rd_data, m_addr, m_data, m_rw, timeout counter = 0; rr pointer = NREQ-1, so requester 0 has top priority first.
- All outputs are registered.
- IDLE:
  - If any req bit is set and m_ready=1, grant the first set bit searching from pointer+1 upward, wrapping modulo NREQ.
  - Latch that requester's addr/data/rw into m_addr/m_data/m_rw, set gnt, move pointer to the winner, go LAUNCH.
  - If m_ready=0, wait; no grant.
- LAUNCH: m_enable=1. When m_ready=0 is sampled, drop m_enable and go WAIT.
- WAIT: m_enable=0. When m_ready=1 is sampled:
  - if rw=1, rd_data <= m_data_out;
  - pulse done[winner]; go COOL.
- COOL (1 cycle): gnt=0, done/err=0, then IDLE. The requester must drop req on the edge where it samples done/err, otherwise a new transaction follows.
- Timeout:
  - Counter clears on entry to LAUNCH and WAIT and increments each cycle in those states.
  - At count==TO_CYC-1: m_enable=0, pulse err[winner], go COOL.
  - rd_data is not updated on timeout.
- Minimum latency: req set to gnt = 1 cycle; m_ready drop to WAIT = 1 cycle; m_ready rise to done = 1 cycle.
- Boundary conditions:
  - Simultaneous requests: strict round-robin; a requester is never granted twice in a row while another is pending.
  - req dropped mid-transaction: no abort; the transaction completes and done/err still pulses.
  - req_* changes after grant: ignored, because the values are latched.
  - Reset mid-transaction: immediate return to the reset values; m_enable falls asynchronously. The master is reset by the same rst.
  - done and err are mutually exclusive. At most one gnt bit is ever set.

Decomposition:
- Package i2c_arb_pkg holds:
  - the state enum IDLE, LAUNCH, WAIT, COOL;
  - ADDR_W=7 and DATA_W=8;
  - default TO_CYC.
- One sub-module, i2c_rr_pick: combinational round-robin selector. Inputs req vector and pointer; outputs one-hot grant, winner index and a valid flag.

Test Plan:
- Single write: req[0]=1, addr=7'h2A, data=8'h1D, rw=0; model master drops ready 2 cycles after enable and raises it 50 cycles later -> gnt=01, m_addr=2A, m_data=1D, done[0] pulses once, rd_data unchanged.
- Read: req[1]=1, rw=1; master returns m_data_out=8'hA5 -> rd_data=A5 in the done[1] cycle, err=0.
- Contention: req=11 held, each requester drops req after done and re-raises 3 cycles later -> grant order 0,1,0,1; never two consecutive grants to the same requester.
- Timeout: TO_CYC=100, master ready stuck high -> m_enable high for 100 cycles, then err[0] pulse, gnt cleared, busy=0 two cycles later.
- Reset mid-op: assert rst=0 during WAIT -> m_enable, gnt, busy = 0 immediately. After release, requester 0 wins a simultaneous req=11.
- Master not ready at request: m_ready=0 while req[0]=1 -> no gnt until m_ready=1, then gnt 1 cycle later.
